// File: rtl/adc_meas_scheduler.sv
// adc_meas_scheduler: issues periodic ADC triggers for a programmed number of
// runs (or continuously), counts completed runs, and buffers ADC output words
// in a small FIFO drained through a valid/ready handshake.
// Optional build macro: ADC_SCHED_OVF_STOP_EN (a FIFO overflow also requests
// a graceful stop of the running sequence).
module adc_meas_scheduler #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned DW         = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic [31:0]                   period,
    input  logic [15:0]                   nburst,
    output logic                          adc_trigger,
    input  logic                          adc_done,
    input  logic                          adc_wr,
    input  logic [DW-1:0]                 adc_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DW-1:0]                 m_data,
    output logic                          busy,
    output logic                          overflow,
    output logic [15:0]                   run_count,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {IDLE, TRIG, WAIT_DONE, GAP} state_t;

    state_t          state;
    logic            stop_pending;
    logic [31:0]     pcnt;
    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   rd_nxt;
    logic [LW-1:0]   level_nxt;
    logic [DW-1:0]   head_nxt;
    logic            pop;
    logic            push;
    logic            full;
    logic            ovf_set;
    logic            ovf_stop;
    logic            end_req;
    logic [15:0]     run_new;
    logic [32:0]     pcnt_inc;

    assign full     = (level == LW'(FIFO_DEPTH));
    assign pop      = m_valid && m_ready;
    assign push     = adc_wr && (!full || pop);
    assign ovf_set  = adc_wr && full && !pop;
    assign run_new  = run_count + 16'd1;
    assign pcnt_inc = {1'b0, pcnt} + 33'd1;
    assign end_req  = stop_pending || stop || ovf_stop;

`ifdef ADC_SCHED_OVF_STOP_EN
    assign ovf_stop = ovf_set;
`else
    assign ovf_stop = 1'b0;
`endif

    // Next occupancy, read pointer and head word; the head bypasses the array
    // when the word being written now becomes the new head.
    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = level - LW'(1);
        end
        rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
        if (push && (wr_ptr == rd_nxt)) begin
            head_nxt = adc_data;
        end else begin
            head_nxt = mem[rd_nxt];
        end
        if (level_nxt == '0) begin
            head_nxt = '0;
        end
    end

    // FIFO storage; contents need no reset because m_data is gated by level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= adc_data;
        end
    end

    // FIFO pointers, occupancy and registered head/valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr  <= rd_nxt;
            level   <= level_nxt;
            m_valid <= (level_nxt != '0);
            m_data  <= head_nxt;
        end
    end

    // Sticky overflow flag, cleared when a new sequence starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if ((state == IDLE) && start) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end
    end

    // Sequencer FSM with registered Moore outputs, run counter and period counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            adc_trigger  <= 1'b0;
            busy         <= 1'b0;
            run_count    <= '0;
            stop_pending <= 1'b0;
            pcnt         <= '0;
        end else begin
            if (pcnt != '1) begin
                pcnt <= pcnt + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= TRIG;
                        adc_trigger  <= 1'b1;
                        busy         <= 1'b1;
                        run_count    <= '0;
                        stop_pending <= 1'b0;
                        pcnt         <= '0;
                    end
                end
                TRIG: begin
                    state       <= WAIT_DONE;
                    adc_trigger <= 1'b0;
                    if (stop || ovf_stop) begin
                        stop_pending <= 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (adc_done) begin
                        run_count <= run_new;
                        if (((nburst != 16'd0) && (run_new == nburst)) || end_req) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (stop || ovf_stop) begin
                        stop_pending <= 1'b1;
                    end
                end
                GAP: begin
                    if (end_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (pcnt_inc >= {1'b0, period}) begin
                        state       <= TRIG;
                        adc_trigger <= 1'b1;
                        pcnt        <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    adc_trigger <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
